// File: rtl/dso_cap_ctrl_pkg.sv
// Shared definitions for the DSO capture controller.
// State encodings are also read back through MCU status, so keep them stable.
package dso_cap_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } cap_state_e;

  function automatic logic is_capturing(input cap_state_e s);
    return (s == ST_PRE) || (s == ST_ARMED) || (s == ST_POST);
  endfunction

endpackage

// File: rtl/dso_cap_ctrl.sv
// Capture controller: pre-trigger fill, armed circular write, post-trigger count, done.
// Sequences sample-RAM writes and reports the trigger address for readout alignment.
module dso_cap_ctrl
  import dso_cap_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              smp_en,
  input  logic              cap_start,
  input  logic              cap_abort,
  input  logic              force_trig,
  input  logic [ADDR_W-1:0] pre_len,
  input  logic              trig_sta,
  input  logic              trig_pluse,
  output logic              trig_clr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              cap_busy,
  output logic              cap_done
);

  localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};

  cap_state_e        state, state_nxt;
  logic [ADDR_W-1:0] pre_q;
  logic [ADDR_W-1:0] pre_clamp;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   post_load;
  logic              trig_evt;
  logic              unused_trig_sta;

  // Trigger status is only observed; sequencing relies on the pulse.
  assign unused_trig_sta = trig_sta;

  // The pre_len port width already bounds the request to DEPTH-1.
  assign pre_clamp = pre_len;
  assign trig_evt  = (state == ST_ARMED) && (trig_pluse || force_trig);
  assign post_load = DEPTH_V - {1'b0, pre_q} - {{ADDR_W{1'b0}}, smp_en};

  assign wr_en    = smp_en && is_capturing(state);
  assign cap_busy = is_capturing(state);
  assign cap_done = (state == ST_DONE);
  assign trig_clr = !((state == ST_ARMED) || (state == ST_POST));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_PRE:   if (smp_en && ((cnt + 1'b1) == {1'b0, pre_q})) state_nxt = ST_ARMED;
      ST_ARMED: if (trig_evt) state_nxt = (post_load == '0) ? ST_DONE : ST_POST;
      ST_POST:  if (smp_en && (cnt == {{ADDR_W{1'b0}}, 1'b1})) state_nxt = ST_DONE;
      default:  state_nxt = state;
    endcase
    if (cap_start) state_nxt = (pre_clamp != '0) ? ST_PRE : ST_ARMED;
    if (cap_abort) state_nxt = ST_IDLE;
  end

  // cnt counts pre-fill samples upward, then is reloaded as the post-trigger down-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr   <= '0;
      trig_addr <= '0;
      pre_q     <= '0;
      cnt       <= '0;
    end else if (cap_abort) begin
      wr_addr   <= wr_addr;
    end else if (cap_start) begin
      wr_addr   <= '0;
      pre_q     <= pre_clamp;
      cnt       <= '0;
    end else begin
      if (wr_en) wr_addr <= wr_addr + 1'b1;
      case (state)
        ST_PRE:   if (smp_en) cnt <= cnt + 1'b1;
        ST_ARMED: if (trig_evt) begin
                    trig_addr <= wr_addr;
                    cnt       <= post_load;
                  end
        ST_POST:  if (smp_en) cnt <= cnt - 1'b1;
        default:  cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_dso_cap_ctrl.sv
// Directed self-checking bench for dso_cap_ctrl with ADDR_W=4 (DEPTH=16).
// Inputs change 1 ns after the rising edge; outputs are checked there too.
module tb_dso_cap_ctrl;

  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              smp_en;
  logic              cap_start;
  logic              cap_abort;
  logic              force_trig;
  logic [ADDR_W-1:0] pre_len;
  logic              trig_sta;
  logic              trig_pluse;
  logic              trig_clr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] trig_addr;
  logic              cap_busy;
  logic              cap_done;

  int tests_run = 0;
  int tests_failed = 0;
  int wr_count = 0;

  dso_cap_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .smp_en     (smp_en),
    .cap_start  (cap_start),
    .cap_abort  (cap_abort),
    .force_trig (force_trig),
    .pre_len    (pre_len),
    .trig_sta   (trig_sta),
    .trig_pluse (trig_pluse),
    .trig_clr   (trig_clr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .trig_addr  (trig_addr),
    .cap_busy   (cap_busy),
    .cap_done   (cap_done)
  );

  always #5 clk = ~clk;

  // One clock cycle with the current inputs; the cycle's write strobe is tallied before the edge.
  task automatic tick();
    #1;
    if (wr_en === 1'b1) wr_count++;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic start, input logic abort, input logic frc,
                               input logic pulse, input logic smp, input logic [ADDR_W-1:0] pre,
                               input int cycles);
    cap_start  = start;
    cap_abort  = abort;
    force_trig = frc;
    trig_pluse = pulse;
    trig_sta   = pulse;
    smp_en     = smp;
    pre_len    = pre;
    for (int i = 0; i < cycles; i++) begin
      tick();
      cap_start  = 1'b0;
      cap_abort  = 1'b0;
      force_trig = 1'b0;
      trig_pluse = 1'b0;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    smp_en = 1'b0; cap_start = 1'b0; cap_abort = 1'b0; force_trig = 1'b0;
    pre_len = '0; trig_sta = 1'b0; trig_pluse = 1'b0;
    tick();
    tick();
    checkOutput("rst_trig_clr", 32'(trig_clr), 1);
    checkOutput("rst_wr_addr", 32'(wr_addr), 0);
    checkOutput("rst_trig_addr", 32'(trig_addr), 0);
    checkOutput("rst_busy", 32'(cap_busy), 0);
    checkOutput("rst_done", 32'(cap_done), 0);
    checkOutput("rst_wr_en", 32'(wr_en), 0);
    rst = 1'b0;

    // Step 1: pre_len=4, continuous strobes, four pre-fill cycles then ARMED.
    wr_count = 0;
    applyStimulus(1, 0, 0, 0, 1, 4'd4, 1);
    checkOutput("s1_busy_pre", 32'(cap_busy), 1);
    checkOutput("s1_clr_pre", 32'(trig_clr), 1);
    checkOutput("s1_addr_start", 32'(wr_addr), 0);
    applyStimulus(0, 0, 0, 0, 1, 4'd4, 3);
    checkOutput("s1_clr_pre3", 32'(trig_clr), 1);
    checkOutput("s1_addr_pre3", 32'(wr_addr), 3);
    applyStimulus(0, 0, 0, 0, 1, 4'd4, 1);
    checkOutput("s1_clr_armed", 32'(trig_clr), 0);
    checkOutput("s1_addr_armed", 32'(wr_addr), 4);
    checkOutput("s1_pre_writes", 32'(wr_count), 4);

    // Step 2: trigger at wr_addr=6 with a strobe; 12 post samples, wrap to 2.
    applyStimulus(0, 0, 0, 0, 1, 4'd4, 2);
    checkOutput("s2_addr_before", 32'(wr_addr), 6);
    wr_count = 0;
    applyStimulus(0, 0, 0, 1, 1, 4'd4, 1);
    checkOutput("s2_trig_addr", 32'(trig_addr), 6);
    checkOutput("s2_busy_post", 32'(cap_busy), 1);
    checkOutput("s2_clr_post", 32'(trig_clr), 0);
    applyStimulus(0, 0, 0, 0, 1, 4'd4, 10);
    checkOutput("s2_not_done_yet", 32'(cap_done), 0);
    applyStimulus(0, 0, 0, 0, 1, 4'd4, 1);
    checkOutput("s2_done", 32'(cap_done), 1);
    checkOutput("s2_busy_done", 32'(cap_busy), 0);
    checkOutput("s2_post_writes", 32'(wr_count), 12);
    checkOutput("s2_final_addr", 32'(wr_addr), 2);
    checkOutput("s2_clr_done", 32'(trig_clr), 1);
    checkOutput("s2_wr_en_done", 32'(wr_en), 0);
    applyStimulus(0, 0, 0, 1, 1, 4'd4, 3);
    checkOutput("s2_addr_frozen", 32'(wr_addr), 2);
    checkOutput("s2_still_done", 32'(cap_done), 1);

    // Step 3: pre_len=0 goes straight to ARMED; pre_len=15 then trigger ends after one sample.
    applyStimulus(1, 0, 0, 0, 1, 4'd0, 1);
    checkOutput("s3_clr_armed0", 32'(trig_clr), 0);
    checkOutput("s3_busy_armed0", 32'(cap_busy), 1);
    checkOutput("s3_addr_armed0", 32'(wr_addr), 0);
    applyStimulus(1, 0, 0, 0, 1, 4'd15, 1);
    checkOutput("s3_clr_pre15", 32'(trig_clr), 1);
    applyStimulus(0, 0, 0, 0, 1, 4'd15, 15);
    checkOutput("s3_clr_armed15", 32'(trig_clr), 0);
    checkOutput("s3_addr_armed15", 32'(wr_addr), 15);
    wr_count = 0;
    applyStimulus(0, 0, 0, 1, 1, 4'd15, 1);
    checkOutput("s3_done15", 32'(cap_done), 1);
    checkOutput("s3_trig_addr15", 32'(trig_addr), 15);
    checkOutput("s3_post_writes15", 32'(wr_count), 1);
    checkOutput("s3_addr_done15", 32'(wr_addr), 0);

    // Step 4: trigger pulse during pre-fill is ignored; force_trig in ARMED triggers.
    applyStimulus(1, 0, 0, 0, 1, 4'd4, 1);
    applyStimulus(0, 0, 0, 1, 1, 4'd4, 1);
    checkOutput("s4_clr_pre_pulse", 32'(trig_clr), 1);
    checkOutput("s4_busy_pre_pulse", 32'(cap_busy), 1);
    checkOutput("s4_trig_addr_kept", 32'(trig_addr), 15);
    applyStimulus(0, 0, 0, 0, 1, 4'd4, 4);
    checkOutput("s4_clr_armed", 32'(trig_clr), 0);
    checkOutput("s4_addr_armed", 32'(wr_addr), 5);
    applyStimulus(0, 0, 1, 0, 1, 4'd4, 1);
    checkOutput("s4_force_trig_addr", 32'(trig_addr), 5);
    checkOutput("s4_force_post", 32'(trig_clr), 0);
    checkOutput("s4_force_not_done", 32'(cap_done), 0);

    // Step 5: abort with simultaneous start mid-POST returns to IDLE, no more writes.
    applyStimulus(0, 0, 0, 0, 1, 4'd4, 2);
    checkOutput("s5_addr_post", 32'(wr_addr), 8);
    applyStimulus(1, 1, 0, 0, 1, 4'd4, 1);
    checkOutput("s5_busy_abort", 32'(cap_busy), 0);
    checkOutput("s5_done_abort", 32'(cap_done), 0);
    checkOutput("s5_clr_abort", 32'(trig_clr), 1);
    checkOutput("s5_addr_abort", 32'(wr_addr), 8);
    checkOutput("s5_trig_addr_abort", 32'(trig_addr), 5);
    wr_count = 0;
    applyStimulus(0, 0, 0, 1, 1, 4'd4, 3);
    checkOutput("s5_writes_idle", 32'(wr_count), 0);
    checkOutput("s5_addr_idle", 32'(wr_addr), 8);

    // Step 6: 1-in-3 strobe duty, then reset asserted in POST.
    applyStimulus(1, 0, 0, 0, 0, 4'd2, 1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 4'd2, 2);
      applyStimulus(0, 0, 0, 0, 1, 4'd2, 1);
      if (i == 0) begin
        checkOutput("s6_clr_pre_duty", 32'(trig_clr), 1);
        checkOutput("s6_addr_pre_duty", 32'(wr_addr), 1);
      end
    end
    checkOutput("s6_clr_armed", 32'(trig_clr), 0);
    checkOutput("s6_addr_armed", 32'(wr_addr), 2);
    applyStimulus(0, 0, 0, 1, 0, 4'd2, 1);
    checkOutput("s6_trig_addr", 32'(trig_addr), 2);
    checkOutput("s6_addr_trig_nostrobe", 32'(wr_addr), 2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 4'd2, 2);
      applyStimulus(0, 0, 0, 0, 1, 4'd2, 1);
    end
    checkOutput("s6_addr_post_duty", 32'(wr_addr), 5);
    checkOutput("s6_busy_post_duty", 32'(cap_busy), 1);
    checkOutput("s6_clr_post_duty", 32'(trig_clr), 0);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 1, 4'd2, 1);
    checkOutput("s6_rst_busy", 32'(cap_busy), 0);
    checkOutput("s6_rst_done", 32'(cap_done), 0);
    checkOutput("s6_rst_clr", 32'(trig_clr), 1);
    checkOutput("s6_rst_wr_addr", 32'(wr_addr), 0);
    checkOutput("s6_rst_trig_addr", 32'(trig_addr), 0);
    checkOutput("s6_rst_wr_en", 32'(wr_en), 0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
